// File: rtl/sat_addsub_acc.sv
// sat_addsub_acc: signed add/sub with saturating accumulator, one-deep valid/ready output stage
module sat_addsub_acc #(
  parameter int WIDTH  = 12,
  parameter bit SAT_EN = 1'b1,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             acc_clr,
  input  logic             ovf_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf,
  output logic [WIDTH-1:0] acc_q,
  output logic             ovf_sticky,
  output logic [CNT_W-1:0] sat_cnt
);
  localparam logic [WIDTH-1:0] MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
  logic             accept, ovf;
  logic [WIDTH-1:0] x, y, res;
  logic [WIDTH:0]   raw;
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  // a same-cycle acc_clr makes the accumulate operate on zero
  always_comb begin
    x   = op[1] ? (acc_clr ? '0 : acc_q) : a;
    y   = op[1] ? a : b;
    raw = op[0] ? {x[WIDTH-1], x} - {y[WIDTH-1], y} : {x[WIDTH-1], x} + {y[WIDTH-1], y};
    ovf = raw[WIDTH] ^ raw[WIDTH-1];
    res = (SAT_EN && ovf) ? (raw[WIDTH] ? MIN : MAX) : raw[WIDTH-1:0];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_ovf    <= 1'b0;
      acc_q      <= '0;
      ovf_sticky <= 1'b0;
      sat_cnt    <= '0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= res;
        out_ovf   <= ovf;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (accept && op[1]) acc_q <= res;
      else if (acc_clr) acc_q <= '0;
      // a new overflow wins over a simultaneous ovf_clr
      if (accept && ovf) begin
        ovf_sticky <= 1'b1;
        sat_cnt    <= ovf_clr ? CNT_W'(1) : (&sat_cnt ? sat_cnt : sat_cnt + CNT_W'(1));
      end else if (ovf_clr) begin
        ovf_sticky <= 1'b0;
        sat_cnt    <= '0;
      end
    end
  end
endmodule

// File: tb/tb_sat_addsub_acc.sv
// tb_sat_addsub_acc: directed scoreboard bench for sat_addsub_acc (saturating and wrapping builds)
module tb_sat_addsub_acc;
  logic        clk = 0, rst = 1;
  logic        in_valid = 0, out_ready = 1, acc_clr = 0, ovf_clr = 0;
  logic [1:0]  op = 0;
  logic [11:0] a = 0, b = 0;
  logic        in_ready, out_valid, out_ovf, ovf_sticky;
  logic [11:0] out_data, acc_q;
  logic [7:0]  sat_cnt;
  logic        w_in_valid = 0, w_in_ready, w_out_valid, w_out_ovf, w_sticky;
  logic [11:0] w_a = 0, w_b = 0, w_out_data, w_acc_q;
  logic [7:0]  w_cnt;
  int          errors = 0, checks = 0;
  int          macc = 0, mcnt = 0;
  bit          mst = 0;
  logic [12:0] q[$];

  always #5 clk = ~clk;

  sat_addsub_acc #(.WIDTH(12), .SAT_EN(1'b1), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
    .acc_clr(acc_clr), .ovf_clr(ovf_clr), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ovf(out_ovf), .acc_q(acc_q), .ovf_sticky(ovf_sticky), .sat_cnt(sat_cnt));

  sat_addsub_acc #(.WIDTH(12), .SAT_EN(1'b0), .CNT_W(8)) dut_wrap (
    .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready), .op(2'b00), .a(w_a), .b(w_b),
    .acc_clr(1'b0), .ovf_clr(1'b0), .out_valid(w_out_valid), .out_ready(1'b1),
    .out_data(w_out_data), .out_ovf(w_out_ovf), .acc_q(w_acc_q), .ovf_sticky(w_sticky), .sat_cnt(w_cnt));

  function automatic int sx(input logic [11:0] v);
    return int'($signed(v));
  endfunction

  // reference: exact integer arithmetic, then range test against the 12-bit signed span
  function automatic logic [12:0] model(input int x, input int y, input bit sub);
    int r;
    logic [31:0] rv;
    bit o;
    r  = sub ? x - y : x + y;
    rv = r;
    o  = (r > 2047) || (r < -2048);
    return {o, o ? (r > 0 ? 12'h7FF : 12'h800) : rv[11:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [1:0] o, input logic [11:0] av, input logic [11:0] bv,
                       input bit aclr, input bit oclr);
    int n = 0;
    logic [12:0] e;
    in_valid = 1; op = o; a = av; b = bv; acc_clr = aclr; ovf_clr = oclr;
    @(negedge clk);
    while (!in_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", 32'(in_ready), 32'd1);
    e = o[1] ? model(aclr ? 0 : macc, sx(av), o[0]) : model(sx(av), sx(bv), o[0]);
    q.push_back(e);
    if (o[1]) macc = sx(e[11:0]);
    else if (aclr) macc = 0;
    if (e[12]) begin
      mst  = 1;
      mcnt = oclr ? 1 : (mcnt == 255 ? 255 : mcnt + 1);
    end else if (oclr) begin
      mst  = 0;
      mcnt = 0;
    end
    @(posedge clk); #1;
    in_valid = 0; acc_clr = 0; ovf_clr = 0;
  endtask

  task automatic pulse(input bit ac, input bit oc);
    acc_clr = ac; ovf_clr = oc;
    @(posedge clk); #1;
    acc_clr = 0; ovf_clr = 0;
    if (ac) macc = 0;
    if (oc) begin
      mst  = 0;
      mcnt = 0;
    end
  endtask

  task automatic chk_status(input string tag);
    chk({tag, "_acc"}, 32'(acc_q), 32'(macc[11:0]));
    chk({tag, "_sticky"}, 32'(ovf_sticky), 32'(mst));
    chk({tag, "_cnt"}, 32'(sat_cnt), 32'(mcnt));
  endtask

  // scoreboard: one pop per output handshake
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      logic [12:0] e;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_output got=%0h exp=none", out_data);
      end else begin
        e = q.pop_front();
        checks++;
        assert (out_data === e[11:0]) else begin
          errors++;
          $error("FAIL out_data got=%0h exp=%0h", out_data, e[11:0]);
        end
        checks++;
        assert (out_ovf === e[12]) else begin
          errors++;
          $error("FAIL out_ovf got=%0b exp=%0b", out_ovf, e[12]);
        end
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_ready", 32'(in_ready), 1);
    chk_status("rst");
    issue(2'b00, 12'h7FF, 12'h001, 0, 0);
    chk("pos_sat_sticky", 32'(ovf_sticky), 1);
    chk("pos_sat_cnt", 32'(sat_cnt), 1);
    issue(2'b00, 12'h800, 12'hFFF, 0, 0);
    issue(2'b01, 12'h000, 12'h800, 0, 0);
    issue(2'b01, 12'h005, 12'h003, 0, 0);
    chk_status("arith");
    pulse(1, 0);
    chk("acc_clr", 32'(acc_q), 0);
    repeat (3) issue(2'b10, 12'd1000, 12'h000, 0, 0);
    chk("acc_sat", 32'(acc_q), 32'd2047);
    issue(2'b11, 12'd47, 12'h000, 0, 0);
    chk("acc_sub", 32'(acc_q), 32'd2000);
    chk_status("accum");
    @(posedge clk); #1;
    out_ready = 0;
    issue(2'b00, 12'd1, 12'd2, 0, 0);
    in_valid = 1; op = 2'b10; a = 12'd10; b = 0;
    repeat (2) begin
      @(negedge clk);
      chk("stall_ready", 32'(in_ready), 0);
      chk("stall_data", 32'(out_data), 3);
      chk("stall_acc", 32'(acc_q), 32'd2000);
    end
    @(posedge clk); #1;
    out_ready = 1;
    issue(2'b10, 12'd10, 12'h000, 0, 0);
    chk("after_stall_acc", 32'(acc_q), 32'd2010);
    pulse(1, 0);
    issue(2'b10, 12'd300, 12'h000, 0, 0);
    chk("acc_300", 32'(acc_q), 32'd300);
    issue(2'b10, 12'd5, 12'h000, 1, 0);
    chk("clr_then_acc", 32'(acc_q), 32'd5);
    pulse(0, 1);
    chk("ovf_clr_sticky", 32'(ovf_sticky), 0);
    chk("ovf_clr_cnt", 32'(sat_cnt), 0);
    issue(2'b00, 12'h7FF, 12'h001, 0, 0);
    issue(2'b00, 12'h7FF, 12'h001, 0, 0);
    chk("cnt_two", 32'(sat_cnt), 2);
    issue(2'b00, 12'h7FF, 12'h001, 0, 1);
    chk("clr_vs_ovf_cnt", 32'(sat_cnt), 1);
    chk("clr_vs_ovf_sticky", 32'(ovf_sticky), 1);
    chk_status("ovfclr");
    repeat (3) @(posedge clk);
    #1 chk("drain", q.size(), 0);
    out_ready = 0;
    issue(2'b10, 12'd7, 12'h000, 0, 0);
    #3 rst = 1;
    q.delete();
    macc = 0; mcnt = 0; mst = 0;
    #1;
    chk("midrst_valid", 32'(out_valid), 0);
    chk("midrst_data", 32'(out_data), 0);
    chk("midrst_ovf", 32'(out_ovf), 0);
    chk_status("midrst");
    @(negedge clk);
    rst = 0;
    out_ready = 1;
    @(posedge clk); #1;
    w_in_valid = 1; w_a = 12'h7FF; w_b = 12'h001;
    @(posedge clk); #1;
    chk("wrap_valid", 32'(w_out_valid), 1);
    chk("wrap_data", 32'(w_out_data), 32'h800);
    chk("wrap_ovf", 32'(w_out_ovf), 1);
    chk("wrap_cnt1", 32'(w_cnt), 1);
    repeat (255) @(posedge clk);
    #1 w_in_valid = 0;
    chk("wrap_cnt_sat", 32'(w_cnt), 255);
    chk("wrap_sticky", 32'(w_sticky), 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
